uart_tx_port: RTL and testbench
===============================

# uart_tx_port

Memory-mapped serial output peripheral for the 8-bit single-cycle processor. It sits downstream of the data-memory store path, next to the parallel output port. A store to the TX data address enqueues the byte in a small FIFO, and the block serialises it as 8N1 on `UART_TXD`. A status byte is exported so the parallel-input read mux can return it to the program.

## Interface
Parameters:
- `CLK_FREQ`, 50_000_000: frequency of `clk` in Hz.
- `BAUD`, 115200: line rate. `DIV` = round(CLK_FREQ/BAUD), must be ≥ 2.
- `DEPTH`, 4: FIFO entries, power of two.
- `TX_ADDR`, 8'hFE: data address. Stores to it enqueue a byte.
- `ST_ADDR`, 8'hFF: status address. Any store to it clears `overflow`.

Ports:
- `clk` input 1: single clock (CLOCK_50). One clock; reset is asynchronous and active-low.
- `rst` input 1: asynchronous, active-low reset (KEY[1]).
- `step` input 1: one-`clk` pulse marking the processor clock edge at which stores commit. Generated by integration from the divided CPU clock.
- `we` input 1: processor MemWrite.
- `Address` input 8: ALU result (store address).
- `WriteData` input 8: register data rd2.
- `txd` output 1: serial line, idle high.
- `status` output 8: {5'b0, overflow, full, busy}.
- `busy` output 1: FSM not IDLE or FIFO non-empty.

## Operation
- Push: a push occurs when `step & we & (Address==TX_ADDR)`. `WriteData` is written at the tail.
  - If the FIFO is full and no pop occurs in the same cycle, the byte is dropped and `overflow` sets (sticky).
  - If a pop occurs in the same cycle as a full-FIFO push, the push is accepted.
- Clear: `step & we & (Address==ST_ADDR)` clears `overflow`. If a clear and an overflow set happen in the same cycle, set wins.
- FIFO: head/tail pointers of log2(DEPTH) bits wrap modulo DEPTH. A count of log2(DEPTH)+1 bits gives `full` = (count==DEPTH) and empty = (count==0).
- FSM states, with a baud counter 0..DIV-1 and a bit index 0..7:
  - IDLE: `txd`=1. If the FIFO is non-empty, pop the head into the shift register, clear the counter, and go to START.
  - START: `txd`=0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: `txd`=shift[0] for DIV cycles. Then shift right and increment the index. After bit 7 completes, go to STOP.
  - STOP: `txd`=1 for DIV cycles. Then, if the FIFO is non-empty, pop and go directly to START, giving back-to-back frames with no extra idle. Otherwise go to IDLE.
- Frame: 10·DIV cycles, LSB first.
- `txd` is driven from a register, so it is glitch-free.
- Pushes during a frame never disturb the frame in flight.

## Timing
- Reset values:
  - `txd`=1, `busy`=0, `status`=8'h00.
  - FIFO empty, state IDLE, counters 0.
- Reset applied mid-frame: `txd` returns high asynchronously and queued bytes are discarded.
- Push latency: a push strobe in cycle n makes the FIFO non-empty from cycle n+1. The FSM pops in cycle n+1, and `txd` falls at the start of cycle n+2.
- `full` and `overflow` update on the cycle after the causing strobe.
- `busy` rises the cycle after the push. It falls the cycle after the final STOP bit of the last queued byte.
- Line rate: baud error equals rounding of DIV only; there is no cumulative drift.

## Structure
- Package `uart_tx_pkg`:
  - State enum typedef `tx_state_t` {IDLE, START, DATA, STOP}.
  - Default address constants `UART_TX_ADDR`, `UART_ST_ADDR`.
  - DIV computation function.
- Sub-module `baud_tick`:
  - Counter with `clear` input and one-cycle `tick` output every DIV cycles.
  - Instantiated once; the FSM clears it on each pop.
- FIFO stays inline as a register array plus pointers.

## Test plan
Bench parameters: CLK_FREQ=8, BAUD=1, so DIV=8.
- Reset, then push 8'hA5 at cycle 10. Required: `txd`=1 through cycle 11, `txd`=0 for cycles 12–19, then bits 1,0,1,0,0,1,0,1 at 8 cycles each, then stop high. `busy` falls at cycle 92.
- Push 8'h01, 8'h02, 8'h03 on consecutive strobes. Required: three frames with no gap between STOP and the next START, and `busy` low only after 30·DIV cycles.
- Push 6 bytes back-to-back while idle (DEPTH=4). Required:
  - `full`=1 after the 5th push (4 queued, 1 in shift).
  - 6th push dropped, `overflow`=1, `status`=8'h07.
  - Only 5 frames are emitted.
- Store to ST_ADDR while `overflow`=1. Required: `status[2]`=0 the next cycle, with no effect on `txd`.
- Assert `rst`=0 during DATA bit 3 of a frame with 2 bytes queued. Required: `txd`=1 immediately, `status`=0, no further frames after release.
- Non-matching address, `we`=0, or `step`=0 with `Address`=TX_ADDR. Required: no push and `txd` stays high.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the memory-mapped 8N1 serial output port.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic [7:0] UART_TX_ADDR = 8'hFE;
  localparam logic [7:0] UART_ST_ADDR = 8'hFF;

  // Clocks per bit, rounded to nearest so the only baud error is this rounding.
  function automatic int calc_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_port_baud_tick.sv
// Bit-period timer: one-cycle tick every DIV clocks, restartable by clear.
module baud_tick #(
  parameter int DIV = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;

  assign tick = (r_cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clear || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_port.sv
// Store-mapped UART transmitter: byte FIFO feeding an 8N1 serialiser with
// back-to-back frames and a sticky overflow flag in the status byte.
module uart_tx_port
  import uart_tx_pkg::*;
#(
  parameter int         CLK_FREQ = 50_000_000,
  parameter int         BAUD     = 115200,
  parameter int         DEPTH    = 4,
  parameter logic [7:0] TX_ADDR  = UART_TX_ADDR,
  parameter logic [7:0] ST_ADDR  = UART_ST_ADDR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic       we,
  input  logic [7:0] Address,
  input  logic [7:0] WriteData,
  output logic       txd,
  output logic [7:0] status,
  output logic       busy,
  output logic [1:0] o_dbg_state
);

  localparam int DIV   = calc_div(CLK_FREQ, BAUD);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;

  tx_state_t        r_state;
  logic [7:0]       r_shift;
  logic [2:0]       r_idx;
  logic             r_txd;

  tx_state_t        w_state_nxt;
  logic [7:0]       w_shift_nxt;
  logic [2:0]       w_idx_nxt;
  logic             w_txd_nxt;
  logic             w_pop;
  logic             w_tick;
  logic             w_push_req;
  logic             w_clr_req;
  logic             w_push_ok;
  logic             w_full;
  logic             w_empty;

  assign w_full     = (r_count == FULL_CNT);
  assign w_empty    = (r_count == '0);
  assign w_push_req = step && we && (Address == TX_ADDR);
  assign w_clr_req  = step && we && (Address == ST_ADDR);
  // A full FIFO still accepts the byte when the serialiser frees a slot this cycle.
  assign w_push_ok  = w_push_req && (!w_full || w_pop);

  baud_tick #(.DIV(DIV)) u_baud_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (w_pop),
    .tick  (w_tick)
  );

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_tail] <= WriteData;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push_req && !w_push_ok) begin
        r_ovf <= 1'b1;
      end else if (w_clr_req) begin
        r_ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_idx   <= '0;
      r_txd   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_idx   <= w_idx_nxt;
      r_txd   <= w_txd_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_idx_nxt   = r_idx;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = r_mem[r_head];
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_tick) begin
          w_idx_nxt   = '0;
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (w_tick) begin
          w_shift_nxt = {1'b0, r_shift[7:1]};
          w_idx_nxt   = r_idx + 1'b1;
          if (r_idx == 3'd7) begin
            w_state_nxt = STOP;
          end
        end
      end
      STOP: begin
        if (w_tick) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = r_mem[r_head];
            w_state_nxt = START;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // The line level is registered from the next state so it changes exactly on the bit boundary.
  always_comb begin
    w_txd_nxt = 1'b1;
    case (w_state_nxt)
      START:   w_txd_nxt = 1'b0;
      DATA:    w_txd_nxt = w_shift_nxt[0];
      default: w_txd_nxt = 1'b1;
    endcase
  end

  assign txd         = r_txd;
  assign busy        = (r_state != IDLE) || !w_empty;
  assign status      = {5'b0, r_ovf, w_full, busy};
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_port.sv
// Bench for uart_tx_port: frame-level reference model, line decoder with a
// scoreboard of expected bytes, directed scenarios and a randomized phase.
module tb_uart_tx_port;

  localparam int         DIV   = 8;
  localparam int         DEPTH = 4;
  localparam logic [7:0] TXA   = 8'hFE;
  localparam logic [7:0] STA   = 8'hFF;

  logic       clk;
  logic       rst;
  logic       step;
  logic       we;
  logic [7:0] Address;
  logic [7:0] WriteData;
  logic       txd;
  logic [7:0] status;
  logic       busy;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending bytes, cycles left in the current frame, frame byte, overflow.
  logic [7:0] m_q [$];
  int         m_left = 0;
  logic [7:0] m_cur  = '0;
  logic       m_ovf  = 1'b0;

  // Scoreboard of bytes whose frames have started on the line.
  logic [7:0] exp_q [$];

  logic       rx_active = 1'b0;
  int         rx_cnt    = 0;
  logic [7:0] rx_byte   = '0;
  int         rx_count  = 0;

  uart_tx_port #(
    .CLK_FREQ (8),
    .BAUD     (1),
    .DEPTH    (DEPTH),
    .TX_ADDR  (TXA),
    .ST_ADDR  (STA)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .step        (step),
    .we          (we),
    .Address     (Address),
    .WriteData   (WriteData),
    .txd         (txd),
    .status      (status),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every cycle: compare outputs with the model, decode the line, then advance the model.
  initial begin
    logic       exp_txd;
    logic       exp_busy;
    int         b;
    int         qsz;
    logic       push;
    logic       clr;
    logic       pop;
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_q.delete();
        exp_q.delete();
        m_left    = 0;
        m_ovf     = 1'b0;
        rx_active = 1'b0;
        check("rst_txd", 16'(txd), 16'd1);
        check("rst_status", 16'(status), 16'h00);
        check("rst_busy", 16'(busy), 16'd0);
      end else begin
        if (m_left > 0) begin
          b = (10 * DIV - m_left) / DIV;
          exp_txd = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : m_cur[b-1];
        end else begin
          exp_txd = 1'b1;
        end
        exp_busy = (m_left > 0) || (m_q.size() > 0);
        check("txd", 16'(txd), 16'(exp_txd));
        check("busy", 16'(busy), 16'(exp_busy));
        check("status", 16'(status),
              16'({5'b0, m_ovf, (m_q.size() == DEPTH), exp_busy}));

        if (!rx_active && txd == 1'b0) begin
          rx_active = 1'b1;
          rx_cnt    = 0;
          rx_byte   = '0;
        end
        if (rx_active) begin
          if (rx_cnt == DIV / 2) check("rx_start", 16'(txd), 16'd0);
          for (int k = 1; k <= 8; k++) begin
            if (rx_cnt == k * DIV + DIV / 2) rx_byte[k-1] = txd;
          end
          if (rx_cnt == 9 * DIV + DIV / 2) begin
            check("rx_stop", 16'(txd), 16'd1);
            check("rx_pending", 16'(exp_q.size() > 0), 16'd1);
            if (exp_q.size() > 0) check("rx_byte", 16'(rx_byte), 16'(exp_q.pop_front()));
            rx_count++;
            rx_active = 1'b0;
          end
          rx_cnt++;
        end

        push = step && we && (Address == TXA);
        clr  = step && we && (Address == STA);
        qsz  = m_q.size();
        pop  = (qsz > 0) && (m_left <= 1);
        if (m_left > 0) m_left--;
        if (pop) begin
          m_cur  = m_q.pop_front();
          m_left = 10 * DIV;
          exp_q.push_back(m_cur);
        end
        if (push && (qsz < DEPTH || pop)) m_q.push_back(WriteData);
        if (clr) m_ovf = 1'b0;
        if (push && !(qsz < DEPTH || pop)) m_ovf = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Holds one bus cycle's worth of processor signals, returning 1ns after the edge that sampled them.
  task automatic drive(input logic s, input logic w, input logic [7:0] a, input logic [7:0] d);
    step = s; we = w; Address = a; WriteData = d;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic wait_busy_low(input int bound, output int k);
    k = 0;
    while (busy !== 1'b0 && k < bound) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    int rx0;
    int a;
    logic [7:0] addr;
    rst = 1'b0; step = 1'b0; we = 1'b0; Address = '0; WriteData = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    check("init_status", 16'(status), 16'h00);
    check("init_txd", 16'(txd), 16'd1);
    idle(5);

    // Single frame: start latency and busy fall time.
    drive(1'b1, 1'b1, TXA, 8'hA5);
    step = 1'b0; we = 1'b0;
    check("t1_busy_rise", 16'(busy), 16'd1);
    check("t1_txd_still_high", 16'(txd), 16'd1);
    k = 0;
    while (txd !== 1'b0 && k < 20) begin @(posedge clk); #1; k++; end
    check("t1_start_lat", 16'(k), 16'd1);
    wait_busy_low(200, k);
    check("t1_busy_fall", 16'(k), 16'(10 * DIV));
    idle(5);

    // Three queued bytes emitted back-to-back.
    rx0 = rx_count;
    drive(1'b1, 1'b1, TXA, 8'h01);
    drive(1'b1, 1'b1, TXA, 8'h02);
    drive(1'b1, 1'b1, TXA, 8'h03);
    step = 1'b0; we = 1'b0;
    wait_busy_low(400, k);
    check("t2_busy_len", 16'(k), 16'(30 * DIV - 1));
    idle(5);
    check("t2_frames", 16'(rx_count - rx0), 16'd3);

    // Overflow: six pushes into a four-deep FIFO.
    rx0 = rx_count;
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, TXA, 8'h10 + 8'(i));
    check("t3_full", 16'(status), 16'h03);
    drive(1'b1, 1'b1, TXA, 8'h99);
    check("t3_ovf_status", 16'(status), 16'h07);
    idle(3);
    drive(1'b1, 1'b1, STA, 8'h00);
    check("t3_ovf_clr", 16'(status[2]), 16'd0);
    wait_busy_low(1000, k);
    check("t3_drained", 16'(busy), 16'd0);
    idle(5);
    check("t3_frames", 16'(rx_count - rx0), 16'd5);

    // Reset during DATA bit 3 of the first of three bytes.
    rx0 = rx_count;
    drive(1'b1, 1'b1, TXA, 8'h37);
    drive(1'b1, 1'b1, TXA, 8'h5A);
    drive(1'b1, 1'b1, TXA, 8'hC3);
    idle(33);
    check("t4_pre_rst_txd", 16'(txd), 16'd0);
    rst = 1'b0;
    #1;
    check("t4_rst_txd", 16'(txd), 16'd1);
    check("t4_rst_status", 16'(status), 16'h00);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    idle(200);
    check("t4_no_frames", 16'(rx_count - rx0), 16'd0);

    // Strobes that must not push.
    rx0 = rx_count;
    drive(1'b1, 1'b1, 8'h10, 8'h55);
    drive(1'b1, 1'b0, TXA, 8'h55);
    drive(1'b0, 1'b1, TXA, 8'h55);
    idle(2);
    check("t5_no_busy", 16'(busy), 16'd0);
    idle(100);
    check("t5_no_frames", 16'(rx_count - rx0), 16'd0);

    // Randomized traffic.
    for (int i = 0; i < 2500; i++) begin
      a = int'($urandom_range(0, 9));
      addr = (a < 6) ? TXA : (a < 8) ? STA : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 99) < 25)
        drive(1'b1, 1'($urandom_range(0, 1)), addr, 8'($urandom_range(0, 255)));
      else
        drive(1'b0, 1'($urandom_range(0, 1)), addr, 8'($urandom_range(0, 255)));
    end
    step = 1'b0; we = 1'b0;
    wait_busy_low(1000, k);
    check("rand_drained", 16'(busy), 16'd0);
    idle(20);
    check("rand_scoreboard_empty", 16'(exp_q.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
